// File: rtl/entrada_dados_pc_if.sv
// Handshake between the IN-instruction input stage and the processor core:
// the control unit raises InRead, the stage answers with Dado/Ready and holds Stall.
interface entrada_dados_pc_if;
    logic        InRead;
    logic [31:0] Dado;
    logic        Stall;
    logic        Ready;

    modport master (output InRead, input  Dado, Stall, Ready);
    modport slave  (input  InRead, output Dado, Stall, Ready);
endinterface

// File: rtl/entrada_dados_pc.sv
// IN-instruction input stage: synchronizes and debounces the Enter key, stalls the
// processor while waiting, and captures a signed 11-bit switch value as a 32-bit word.
module entrada_dados_pc #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [9:0]          Switches,
    input  logic                SignSw,
    input  logic                Key_n,
    output logic                LedWait,
    entrada_dados_pc_if.slave   bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       sync_vld_q, sync_vld_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;
    state_t           state_q, state_d;
    logic [31:0]      dado_q, dado_d;

    logic        ready;
    logic        capture;
    logic [31:0] magnitude;
    logic [31:0] value;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sync1_d    = Key_n;
        sync2_d    = sync1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        deb_d      = deb_q;
        cnt_d      = '0;
        press_d    = 1'b0;
        // A key held through Reset must first be seen released before it may press;
        // sync_vld masks the reset values still flowing through the synchronizer.
        armed_d    = armed_q | (sync_vld_q[1] & sync2_q & deb_q);
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d   = sync2_q;
                press_d = armed_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.InRead) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!bus.InRead)  state_d = ST_IDLE;
                else if (press_q) state_d = ST_DONE;
            end
            ST_DONE: if (bus.InRead) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        magnitude = {22'b0, Switches};
        value     = SignSw ? (~magnitude + 32'd1) : magnitude;
        ready     = (state_q == ST_DONE);
        capture   = (state_q == ST_WAIT) & bus.InRead & press_q;
        dado_d    = capture ? value : dado_q;
        LedWait   = (state_q == ST_WAIT);
        bus.Ready = ready;
        bus.Stall = bus.InRead & ~ready;
        bus.Dado  = dado_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sync_vld_q <= '0;
            deb_q      <= 1'b1;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            press_q    <= 1'b0;
            state_q    <= ST_IDLE;
            dado_q     <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync_vld_q <= sync_vld_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            press_q    <= press_d;
            state_q    <= state_d;
            dado_q     <= dado_d;
        end
    end

endmodule

// File: tb/tb_entrada_dados_pc.sv
// Randomized self-checking bench for entrada_dados_pc with a short debounce window.
module tb_entrada_dados_pc;

    localparam int DEB     = 4;
    localparam int LATENCY = 2 + DEB + 1;
    localparam int TIMEOUT = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] switches;
    logic       sign_sw;
    logic       key_n;
    logic       led_wait;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] last_dado = '0;

    entrada_dados_pc_if bus ();

    entrada_dados_pc #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
        .CLK      (clk),
        .Reset    (rst),
        .Switches (switches),
        .SignSw   (sign_sw),
        .Key_n    (key_n),
        .LedWait  (led_wait),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected word straight from integer arithmetic on the entered value.
    function automatic logic [31:0] ref_value(input int sw, input bit sign);
        int v;
        v = sign ? -sw : sw;
        return 32'(v);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advances until Ready or timeout; returns cycles taken (-1 on timeout) and
    // whether Stall/LedWait stayed high the whole wait.
    task automatic wait_ready(output int lat, output bit held);
        lat  = -1;
        held = 1'b1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (bus.Stall !== 1'b1 || led_wait !== 1'b1) held = 1'b0;
            tick(1);
            if (bus.Ready === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_capture(input int sw, input bit sign);
        int lat;
        bit held;
        logic [31:0] exp;
        exp      = ref_value(sw, sign);
        switches = 10'(sw);
        sign_sw  = sign;
        bus.InRead = 1'b1;
        tick(2);
        key_n = 1'b0;
        wait_ready(lat, held);
        tests_run++;
        if (lat !== LATENCY) begin
            $display("FAIL capture_latency sw=%0d sign=%0d: got %0d want %0d", sw, sign, lat, LATENCY);
            tests_failed++;
        end
        tests_run++;
        if (!held) begin
            $display("FAIL wait_stall_led sw=%0d: Stall/LedWait dropped before capture, want held 1", sw);
            tests_failed++;
        end
        tests_run++;
        if (bus.Dado !== exp || bus.Stall !== 1'b0 || led_wait !== 1'b0) begin
            $display("FAIL capture_word sw=%0d sign=%0d: Dado=%h Stall=%b Led=%b want Dado=%h Stall=0 Led=0",
                     sw, sign, bus.Dado, bus.Stall, led_wait, exp);
            tests_failed++;
        end
        last_dado = exp;
        switches  = 10'($urandom);
        sign_sw   = ~sign;
        tick(1);
        tests_run++;
        if (bus.Ready !== 1'b0 || bus.Dado !== exp) begin
            $display("FAIL consume sw=%0d: Ready=%b Dado=%h want Ready=0 Dado=%h", sw, bus.Ready, bus.Dado, exp);
            tests_failed++;
        end
        bus.InRead = 1'b0;
        key_n      = 1'b1;
        tick(3 * DEB);
    endtask

    task automatic test_reset;
        key_n = 1'b0; bus.InRead = 1'b0; switches = '0; sign_sw = 1'b0;
        rst = 1'b1;
        tick(2);
        tests_run++;
        if (bus.Dado !== 32'd0 || bus.Ready !== 1'b0 || bus.Stall !== 1'b0 || led_wait !== 1'b0) begin
            $display("FAIL reset_outputs: Dado=%h Ready=%b Stall=%b Led=%b want 0/0/0/0",
                     bus.Dado, bus.Ready, bus.Stall, led_wait);
            tests_failed++;
        end
        rst = 1'b0;
        bus.InRead = 1'b1;
        switches   = 10'd5;
        tick(25);
        tests_run++;
        if (bus.Ready !== 1'b0 || bus.Stall !== 1'b1) begin
            $display("FAIL held_key_after_reset: Ready=%b Stall=%b want Ready=0 Stall=1", bus.Ready, bus.Stall);
            tests_failed++;
        end
        key_n = 1'b1;
        tick(3 * DEB);
        test_capture(5, 1'b0);
    endtask

    task automatic test_toggle;
        int lat;
        bit held;
        int early;
        early = 0;
        switches = 10'd321; sign_sw = 1'b1; bus.InRead = 1'b1;
        tick(2);
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < 2; c++) begin
                tick(1);
                if (bus.Ready === 1'b1) early++;
            end
        end
        tests_run++;
        if (early !== 0) begin
            $display("FAIL toggle_no_capture: Ready seen %0d cycles during bounce, want 0", early);
            tests_failed++;
        end
        key_n = 1'b0;
        wait_ready(lat, held);
        tests_run++;
        if (lat !== LATENCY || bus.Dado !== ref_value(321, 1'b1)) begin
            $display("FAIL toggle_capture: lat=%0d Dado=%h want lat=%0d Dado=%h", lat, bus.Dado, LATENCY, ref_value(321, 1'b1));
            tests_failed++;
        end
        last_dado = ref_value(321, 1'b1);
        tick(1);
        bus.InRead = 1'b0;
        key_n = 1'b1;
        tick(3 * DEB);
    endtask

    task automatic test_glitch_and_abort;
        int seen;
        seen = 0;
        bus.InRead = 1'b1; switches = 10'd77;
        tick(2);
        key_n = 1'b0;
        tick(DEB - 1);
        key_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.Ready === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0 || bus.Stall !== 1'b1 || led_wait !== 1'b1) begin
            $display("FAIL glitch_ignored: ready_cycles=%0d Stall=%b Led=%b want 0/1/1", seen, bus.Stall, led_wait);
            tests_failed++;
        end
        bus.InRead = 1'b0;
        tick(1);
        tests_run++;
        if (bus.Ready !== 1'b0 || bus.Stall !== 1'b0 || led_wait !== 1'b0 || bus.Dado !== last_dado) begin
            $display("FAIL abort_wait: Ready=%b Stall=%b Led=%b Dado=%h want 0/0/0 Dado=%h",
                     bus.Ready, bus.Stall, led_wait, bus.Dado, last_dado);
            tests_failed++;
        end
    endtask

    task automatic test_idle_press;
        int lat;
        bit held;
        bus.InRead = 1'b0; switches = 10'd600; sign_sw = 1'b0;
        key_n = 1'b0;
        tick(15);
        bus.InRead = 1'b1;
        tick(20);
        tests_run++;
        if (bus.Ready !== 1'b0 || bus.Stall !== 1'b1 || led_wait !== 1'b1) begin
            $display("FAIL idle_press_discarded: Ready=%b Stall=%b Led=%b want 0/1/1", bus.Ready, bus.Stall, led_wait);
            tests_failed++;
        end
        key_n = 1'b1;
        tick(3 * DEB);
        key_n = 1'b0;
        wait_ready(lat, held);
        tests_run++;
        if (lat !== LATENCY || bus.Dado !== ref_value(600, 1'b0)) begin
            $display("FAIL fresh_press_capture: lat=%0d Dado=%h want lat=%0d Dado=%h", lat, bus.Dado, LATENCY, ref_value(600, 1'b0));
            tests_failed++;
        end
        last_dado = ref_value(600, 1'b0);
        tick(1);
        tick(20);
        tests_run++;
        if (bus.Ready !== 1'b0 || bus.Stall !== 1'b1 || bus.Dado !== last_dado) begin
            $display("FAIL held_key_second_in: Ready=%b Stall=%b Dado=%h want Ready=0 Stall=1 Dado=%h",
                     bus.Ready, bus.Stall, bus.Dado, last_dado);
            tests_failed++;
        end
        bus.InRead = 1'b0;
        key_n = 1'b1;
        tick(3 * DEB);
    endtask

    task automatic test_reset_in_wait;
        bus.InRead = 1'b1;
        tick(3);
        tests_run++;
        if (led_wait !== 1'b1) begin
            $display("FAIL enter_wait: LedWait=%b want 1", led_wait);
            tests_failed++;
        end
        rst = 1'b1; bus.InRead = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        tests_run++;
        if (bus.Dado !== 32'd0 || bus.Ready !== 1'b0 || bus.Stall !== 1'b0 || led_wait !== 1'b0) begin
            $display("FAIL reset_in_wait: Dado=%h Ready=%b Stall=%b Led=%b want 0/0/0/0",
                     bus.Dado, bus.Ready, bus.Stall, led_wait);
            tests_failed++;
        end
        last_dado = '0;
        tick(3 * DEB);
        test_capture(999, 1'b1);
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; bus.InRead = 1'b0; switches = '0; sign_sw = 1'b0;
        test_reset();
        test_capture(437, 1'b0);
        test_capture(1023, 1'b1);
        test_capture(0, 1'b1);
        test_capture(1023, 1'b0);
        for (int i = 0; i < 8; i++)
            test_capture(int'($urandom_range(0, 1023)), bit'($urandom_range(0, 1)));
        test_toggle();
        test_glitch_and_abort();
        test_idle_press();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
